// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-field and control bundle between the datapath and pipeline_hazard_ctrl.
// master: datapath side (drives ID/EX/MEM fields, consumes enables/flushes).
// slave : hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID stage fields
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  // EX stage fields
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  // MEM stage handshake
  logic             mem_req;
  logic             mem_ready;
  // pipeline register controls
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_bubble;
  // status and performance
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output ex_memread, ex_rt, ex_branch_taken,
    output mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    input  exmem_en, memwb_en, memwb_bubble,
    input  mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  ex_memread, ex_rt, ex_branch_taken,
    input  mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    output exmem_en, memwb_en, memwb_bubble,
    output mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for a 5-stage pipeline.
// Produces PC / IF/ID / ID/EX / EX/MEM / MEM/WB enables and flushes for
// load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
// Controls are combinational (zero added latency); only the RUN/MEM_WAIT
// state, the wait counter and the sticky watchdog flag are registered.
// Optional feature macro: STALL_COUNT_EN builds the stall/flush perf counters;
// when undefined both counter outputs are tied to 0 and no flops are built.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // Watchdog fires on the MEM_WAIT edge that sees wait_cnt == TIMEOUT-1.
  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             mem_timeout_q;

  logic hazard;
  logic mem_block;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_en, memwb_bubble;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard = hz.ex_memread && (hz.ex_rt != 5'd0) &&
             ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  end

  // Memory stall this cycle: a new unfinished access in RUN, or still waiting in MEM_WAIT.
  always_comb begin
    if (state_q == ST_RUN) begin
      mem_block = hz.mem_req && !hz.mem_ready;
    end else begin
      mem_block = !hz.mem_ready;
    end
  end

  // Pipeline controls by priority: memory freeze, branch flush, load-use stall, flow.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      if (mem_block) begin
        // Freeze upstream, drain a bubble into WB so nothing retires twice.
        memwb_en     = 1'b1;
        memwb_bubble = 1'b1;
      end else if (hz.ex_branch_taken) begin
        // Wrong-path instructions in IF/ID and ID/EX are squashed.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (hazard) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX while the load advances.
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // RUN/MEM_WAIT sequencing, wait counter and sticky watchdog flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.mem_req && !hz.mem_ready) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!hz.mem_ready) begin
            if (wait_cnt_q != {CNT_W{1'b1}}) begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (WD_EN && (wait_cnt_q == WD_LAST)) begin
              mem_timeout_q <= 1'b1;
            end
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.mem_timeout  = mem_timeout_q;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  // Saturating counts of PC-stalled cycles and IF/ID flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_en && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
      if (ifid_flush && (flush_count_q != {CNT_W{1'b1}})) begin
        flush_count_q <= flush_count_q + 1'b1;
      end
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl.
// Two instances share one stimulus stream: one with TIMEOUT=4, one with the
// watchdog disabled (TIMEOUT=0). A cycle-level reference model tracks whether
// the pipeline is waiting on memory, how long, and the perf counts.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz4 ();
  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz0 ();

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut4 (
    .clk(clk), .reset(reset), .hz(hz4.slave)
  );
  pipeline_hazard_ctrl #(.TIMEOUT(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .hz(hz0.slave)
  );

  // Control vector order: pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb, bubble
  localparam logic [7:0] V_FREEZE = 8'b0000_0011;
  localparam logic [7:0] V_BRANCH = 8'b1111_1110;
  localparam logic [7:0] V_STALL  = 8'b0001_1110;
  localparam logic [7:0] V_FLOW   = 8'b1101_0110;

  logic [7:0] ctrl4, ctrl0;
  assign ctrl4 = {hz4.pc_en, hz4.ifid_en, hz4.ifid_flush, hz4.idex_en,
                  hz4.idex_flush, hz4.exmem_en, hz4.memwb_en, hz4.memwb_bubble};
  assign ctrl0 = {hz0.pc_en, hz0.ifid_en, hz0.ifid_flush, hz0.idex_en,
                  hz0.idex_flush, hz0.exmem_en, hz0.memwb_en, hz0.memwb_bubble};

  // Stimulus shadow
  logic [4:0] s_rs, s_rt, s_exrt;
  logic       s_uses, s_memread, s_br, s_req, s_rdy;

  // Reference model
  bit waiting;      // a data-memory access is outstanding
  int waited;       // MEM_WAIT cycles seen with mem_ready low
  bit timed_out;    // watchdog state for the TIMEOUT=4 instance
  int n_stall, n_flush;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic memread, input logic [4:0] exrt, input logic br,
                       input logic req, input logic rdy);
    s_rs = rs; s_rt = rt; s_uses = uses; s_memread = memread;
    s_exrt = exrt; s_br = br; s_req = req; s_rdy = rdy;
    hz4.id_rs = rs; hz4.id_rt = rt; hz4.id_uses_rt = uses; hz4.ex_memread = memread;
    hz4.ex_rt = exrt; hz4.ex_branch_taken = br; hz4.mem_req = req; hz4.mem_ready = rdy;
    hz0.id_rs = rs; hz0.id_rt = rt; hz0.id_uses_rt = uses; hz0.ex_memread = memread;
    hz0.ex_rt = exrt; hz0.ex_branch_taken = br; hz0.mem_req = req; hz0.mem_ready = rdy;
  endtask

  task automatic apply_idle();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [7:0] expected_ctrl();
    bit loaduse;
    loaduse = s_memread && s_exrt != 0 &&
              (s_exrt == s_rs || (s_uses && s_exrt == s_rt));
    if (!reset) return 8'h00;
    if ((waiting && !s_rdy) || (!waiting && s_req && !s_rdy)) return V_FREEZE;
    if (s_br) return V_BRANCH;
    if (loaduse) return V_STALL;
    return V_FLOW;
  endfunction

  function automatic int exp_stall();
`ifdef STALL_COUNT_EN
    return n_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush();
`ifdef STALL_COUNT_EN
    return n_flush;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    waiting = 0; waited = 0; timed_out = 0; n_stall = 0; n_flush = 0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".tmo4"}, 32'(hz4.mem_timeout), 32'(timed_out));
    check_eq({tag, ".tmo0"}, 32'(hz0.mem_timeout), 32'd0);
    check_eq({tag, ".stall"}, 32'(hz4.stall_cycles), 32'(exp_stall()));
    check_eq({tag, ".flush"}, 32'(hz4.flush_count), 32'(exp_flush()));
    check_eq({tag, ".stall0"}, 32'(hz0.stall_cycles), 32'(exp_stall()));
    check_eq({tag, ".flush0"}, 32'(hz0.flush_count), 32'(exp_flush()));
  endtask

  // One cycle: check combinational controls mid-cycle, then advance model on the edge.
  task automatic step(input string tag);
    logic [7:0] e;
    e = expected_ctrl();
    @(negedge clk);
    step_no++;
    check_eq({tag, ".ctrl4"}, 32'(ctrl4), 32'(e));
    check_eq({tag, ".ctrl0"}, 32'(ctrl0), 32'(e));
    check_status(tag);
    $display("step %0d %s ctrl=%b exp=%b wait=%0d tmo=%0b", step_no, tag, ctrl4, e,
             waited, hz4.mem_timeout);
    @(posedge clk);
    if (!e[7] && n_stall < CNT_MAX) n_stall++;
    if (e[5] && n_flush < CNT_MAX) n_flush++;
    if (!waiting) begin
      if (s_req && !s_rdy) begin
        waiting = 1;
        waited  = 0;
      end
    end else if (!s_rdy) begin
      if (waited == 4 - 1) timed_out = 1;
      if (waited < CNT_MAX) waited++;
    end else begin
      waiting = 0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    apply_idle();
    model_reset();
    #2;
    check_eq("rst.ctrl4", 32'(ctrl4), 32'd0);
    check_eq("rst.ctrl0", 32'(ctrl0), 32'd0);
    check_status("rst");
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_edge.ctrl4", 32'(ctrl4), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on rs, then the same load-use through rt
    apply(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    check_eq("loaduse.direct", 32'(expected_ctrl()), 32'(V_STALL));
    step("loaduse");
    apply_idle();
    step("after_loaduse");
    apply(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    step("loaduse_rt");

    // No false hazards
    apply(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("r0_nohaz");
    apply(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    step("rt_unused");

    // Branch beats hazard
    apply(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    step("branch_haz");

    // Three-cycle memory wait, ready on the fourth
    repeat (3) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("memwait");
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("memready");
    apply_idle();
    step("after_mem");

    // Watchdog: hold ready low long enough to expire TIMEOUT=4, then release
    repeat (7) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("watchdog");
    end
    apply(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1);
    step("wd_ready_haz");
    apply_idle();
    step("wd_sticky");
    check_eq("wd_sticky.direct", 32'(hz4.mem_timeout), 32'd1);

    // Async reset mid-MEM_WAIT, between clock edges
    repeat (2) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("pre_arst");
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("arst.ctrl4", 32'(ctrl4), 32'd0);
    check_eq("arst.ctrl0", 32'(ctrl0), 32'd0);
    check_status("arst");
    apply_idle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("post_arst");
    check_eq("post_arst.pc_en", 32'(hz4.pc_en), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] rs, rt, exrt;
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      exrt = 5'($urandom_range(0, 3));
      apply(rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), exrt,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage pipeline. Drives enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Handles three cases: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits, using a small FSM. Sits beside the datapath and consumes ID/EX/MEM stage fields; its outputs gate the register write enables.

Parameters:
TIMEOUT, 64, MEM_WAIT cycles with mem_ready=0 before mem_timeout sets; 0 disables the watchdog
CNT_W, 16, width of wait counter and optional performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  destination register of the load in EX
ex_branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear to NOP
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear (control bits 0)
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
memwb_bubble  out  1  MEM/WB loads regwrite=0, memtoreg=0
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  optional perf counter
flush_count  out  CNT_W  optional perf counter

Behaviour:
- Reset (reset=0, async): state=RUN, wait_cnt=0, mem_timeout=0, counters=0. All enables, flushes and memwb_bubble are forced 0 while reset is low.
- Controls are combinational from state and inputs. Zero added latency.
- FSM states: RUN, MEM_WAIT.
- freeze set: pc_en=ifid_en=idex_en=exmem_en=0; memwb_en=1, memwb_bubble=1; flushes 0.
- hazard = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN priority, highest first:
  1. mem_req & !mem_ready: freeze; next state=MEM_WAIT; wait_cnt<=0.
  2. ex_branch_taken: all enables 1; ifid_flush=1, idex_flush=1. Takes precedence over hazard.
  3. hazard: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1; exmem_en=memwb_en=1.
  4. otherwise: all enables 1; flushes and bubble 0.
- MEM_WAIT, mem_ready=0: freeze. wait_cnt increments, saturating at all-ones. If TIMEOUT!=0 and wait_cnt==TIMEOUT-1, mem_timeout<=1. State stays frozen after timeout.
- MEM_WAIT, mem_ready=1: evaluate RUN rules 2-4 in the same cycle; next state=RUN.
- mem_timeout clears only on reset.
- Back-to-back memory stalls: RUN with mem_req & !mem_ready re-enters MEM_WAIT with wait_cnt=0.
- Reset asserted mid-MEM_WAIT returns immediately to RUN with all controls 0.

Optional Feature:
STALL_COUNT_EN defined:
- stall_cycles increments each cycle pc_en=0 (reset not asserted), saturating at 2^CNT_W-1.
- flush_count increments each cycle ifid_flush=1, saturating.
Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 for exactly that cycle.
- No false hazard: ex_rt=0, id_rs=0, ex_memread=1 -> all enables 1, no flush. id_uses_rt=0 with id_rt=ex_rt=7 -> no stall.
- Branch vs hazard: ex_branch_taken=1 with the hazard condition true -> ifid_flush=idex_flush=1, pc_en=1; flush_count +1 when STALL_COUNT_EN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 freeze cycles with memwb_bubble=1; RUN with all enables 1 on the ready cycle; stall_cycles=3.
- Watchdog: TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th MEM_WAIT edge and stays 1 after mem_ready=1; with TIMEOUT=0 it never sets.
- Async reset: drop reset mid-MEM_WAIT without a clock edge -> all controls 0 immediately. Release, then one edge -> state RUN, pc_en=1.
